// File: rtl/sfu_array_if.sv
// Handshake bundle for sfu_array: write/bypass input, addressed read request and result output.
// The master drives it from upstream; sfu_array itself sits on the slave modport.
interface sfu_array_if #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int DEPTH   = 16
);
    localparam int AW = $clog2(DEPTH);

    logic                     os_or_ws;
    logic                     relu_en;
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_first;
    logic [AW-1:0]            in_addr;
    logic [COL*PSUM_BW-1:0]   psum_in;
    logic                     rd_req;
    logic [AW-1:0]            rd_addr;
    logic                     rd_clear;
    logic                     rd_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [COL*PSUM_BW-1:0]   psum_out;

    modport master (
        output os_or_ws, relu_en, in_valid, in_first, in_addr, psum_in,
               rd_req, rd_addr, rd_clear, out_ready,
        input  in_ready, rd_ready, out_valid, psum_out
    );

    modport slave (
        input  os_or_ws, relu_en, in_valid, in_first, in_addr, psum_in,
               rd_req, rd_addr, rd_clear, out_ready,
        output in_ready, rd_ready, out_valid, psum_out
    );
endinterface

// File: rtl/sfu_array.sv
// COL-channel special-function unit: per-channel accumulator banks with a ReLU'd registered read port,
// or a straight ReLU bypass in output-stationary mode. Define SFU_SAT_EN for saturating accumulation.
module sfu_array #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int DEPTH   = 16
) (
    input  logic      clk,
    input  logic      reset_n,
    sfu_array_if.slave bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t state, state_nxt;

    logic signed [PSUM_BW-1:0] mem     [DEPTH][COL];
    logic signed [PSUM_BW-1:0] in_p0   [COL];
    logic signed [PSUM_BW-1:0] load_p0 [COL];
    logic signed [PSUM_BW-1:0] data_p1 [COL];

    logic vld_p1;
    logic free;
    logic wr_fire;
    logic os_fire;
    logic rd_fire;
    logic load;

    function automatic logic signed [PSUM_BW-1:0] relu(input logic signed [PSUM_BW-1:0] x,
                                                       input logic en);
        return (en && x[PSUM_BW-1]) ? '0 : x;
    endfunction

    function automatic logic signed [PSUM_BW-1:0] acc_add(input logic signed [PSUM_BW-1:0] a,
                                                          input logic signed [PSUM_BW-1:0] b);
        logic signed [PSUM_BW-1:0] sum;
        sum = a + b;
`ifdef SFU_SAT_EN
        // Same-sign operands whose sum flips sign have overflowed; clamp toward the operand sign.
        if ((a[PSUM_BW-1] == b[PSUM_BW-1]) && (sum[PSUM_BW-1] != a[PSUM_BW-1]))
            sum = a[PSUM_BW-1] ? {1'b1, {(PSUM_BW-1){1'b0}}} : {1'b0, {(PSUM_BW-1){1'b1}}};
`endif
        return sum;
    endfunction

    assign vld_p1       = (state == HOLD);
    assign free         = !vld_p1 || bus.out_ready;
    // WS writes never wait on the output; reads yield to any pending write.
    assign bus.in_ready = bus.os_or_ws ? free : 1'b1;
    assign bus.rd_ready = !bus.os_or_ws && !bus.in_valid && free;

    assign wr_fire = bus.in_valid && bus.in_ready && !bus.os_or_ws;
    assign os_fire = bus.in_valid && bus.in_ready &&  bus.os_or_ws;
    assign rd_fire = bus.rd_req && bus.rd_ready;
    assign load    = os_fire || rd_fire;

    // Stage p0: channel unpack and output-value select
    always_comb begin
        for (int c = 0; c < COL; c++) begin
            in_p0[c]   = $signed(bus.psum_in[c*PSUM_BW +: PSUM_BW]);
            load_p0[c] = relu(bus.os_or_ws ? in_p0[c] : mem[bus.rd_addr][c], bus.relu_en);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int d = 0; d < DEPTH; d++)
                for (int c = 0; c < COL; c++)
                    mem[d][c] <= '0;
        end else if (wr_fire) begin
            for (int c = 0; c < COL; c++)
                mem[bus.in_addr][c] <= bus.in_first ? in_p0[c] : acc_add(mem[bus.in_addr][c], in_p0[c]);
        end else if (rd_fire && bus.rd_clear) begin
            for (int c = 0; c < COL; c++)
                mem[bus.rd_addr][c] <= '0;
        end
    end

    // Stage p1: output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < COL; c++)
                data_p1[c] <= '0;
        end else if (load) begin
            for (int c = 0; c < COL; c++)
                data_p1[c] <= load_p0[c];
        end
    end

    for (genvar c = 0; c < COL; c++) begin : g_pack
        assign bus.psum_out[c*PSUM_BW +: PSUM_BW] = data_p1[c];
    end

    assign bus.out_valid = vld_p1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = HOLD;
            HOLD:    if (bus.out_ready && !load) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sfu_array.sv
// Directed bench for sfu_array: WS accumulate/read, ReLU with clear, overflow, OS handshake,
// write-over-read priority and asynchronous reset.
module tb_sfu_array;
    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int DEPTH   = 16;
    localparam int W       = COL * PSUM_BW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sfu_array_if #(.COL(COL), .PSUM_BW(PSUM_BW), .DEPTH(DEPTH)) bus ();

    sfu_array #(.COL(COL), .PSUM_BW(PSUM_BW), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rep(input int v);
        logic [W-1:0] r;
        for (int c = 0; c < COL; c++) r[c*PSUM_BW +: PSUM_BW] = v[PSUM_BW-1:0];
        return r;
    endfunction

    function automatic logic [W-1:0] set_ch(input logic [W-1:0] vec, input int c, input int v);
        logic [W-1:0] r;
        r = vec;
        r[c*PSUM_BW +: PSUM_BW] = v[PSUM_BW-1:0];
        return r;
    endfunction

    // Beat k, channel c: magnitude 10k+c+1, negative on odd channels.
    function automatic logic [W-1:0] os_beat(input int k, input bit relu);
        logic [W-1:0] r;
        int v;
        for (int c = 0; c < COL; c++) begin
            v = k * 10 + c + 1;
            if (c % 2 == 1) v = -v;
            if (relu && v < 0) v = 0;
            r[c*PSUM_BW +: PSUM_BW] = v[PSUM_BW-1:0];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ws_write(input int addr, input bit first, input logic [W-1:0] vec);
        bus.in_valid = 1'b1;
        bus.in_addr  = addr[3:0];
        bus.in_first = first;
        bus.psum_in  = vec;
        tick();
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
    endtask

    task automatic ws_read(input int addr, input bit clear, input bit relu,
                           output logic [W-1:0] data, output logic vld);
        bus.rd_req   = 1'b1;
        bus.rd_addr  = addr[3:0];
        bus.rd_clear = clear;
        bus.relu_en  = relu;
        tick();
        bus.rd_req   = 1'b0;
        bus.rd_clear = 1'b0;
        data = bus.psum_out;
        vld  = bus.out_valid;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] d;
        logic         v;
        logic [W-1:0] vec;

        bus.os_or_ws  = 1'b0;
        bus.relu_en   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.in_addr   = '0;
        bus.psum_in   = '0;
        bus.rd_req    = 1'b0;
        bus.rd_addr   = '0;
        bus.rd_clear  = 1'b0;
        bus.out_ready = 1'b1;

        #3;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_psum_out", bus.psum_out, '0);
        check("rst_in_ready_ws", bus.in_ready, 1'b1);
        #10 reset_n = 1'b1;
        tick();

        // WS accumulate: 100 - 30 + 5 = 75
        ws_write(3, 1'b1, rep(100));
        ws_write(3, 1'b0, rep(-30));
        ws_write(3, 1'b0, rep(5));
        ws_read(3, 1'b0, 1'b0, d, v);
        check("acc_valid", v, 1'b1);
        check("acc_data", d, rep(75));
        tick();
        check("acc_valid_drop", bus.out_valid, 1'b0);

        // ReLU and clear: ch0 -> -40, ch1 -> 12
        vec = set_ch(set_ch('0, 0, -50), 1, 10);
        ws_write(5, 1'b1, vec);
        vec = set_ch(set_ch('0, 0, 10), 1, 2);
        ws_write(5, 1'b0, vec);
        ws_read(5, 1'b1, 1'b1, d, v);
        check("relu_valid", v, 1'b1);
        check("relu_data", d, set_ch('0, 1, 12));
        ws_write(5, 1'b0, rep(7));
        ws_read(5, 1'b0, 1'b0, d, v);
        check("clear_then_acc", d, rep(7));

        // Overflow in both directions
        ws_write(7, 1'b1, rep(32760));
        ws_write(7, 1'b0, rep(20));
        ws_read(7, 1'b0, 1'b0, d, v);
`ifdef SFU_SAT_EN
        check("ovf_pos", d, rep(32767));
`else
        check("ovf_pos", d, rep(-32756));
`endif
        ws_write(8, 1'b1, rep(-32760));
        ws_write(8, 1'b0, rep(-20));
        ws_read(8, 1'b0, 1'b0, d, v);
`ifdef SFU_SAT_EN
        check("ovf_neg", d, rep(-32768));
`else
        check("ovf_neg", d, rep(32756));
`endif

        // Priority: simultaneous write and read, write wins, read sees 1 + 10
        ws_write(2, 1'b1, rep(1));
        bus.in_valid = 1'b1;
        bus.in_addr  = 4'd2;
        bus.in_first = 1'b0;
        bus.psum_in  = rep(10);
        bus.rd_req   = 1'b1;
        bus.rd_addr  = 4'd2;
        bus.relu_en  = 1'b0;
        #1;
        check("prio_rd_ready_low", bus.rd_ready, 1'b0);
        check("prio_in_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("prio_rd_ready_high", bus.rd_ready, 1'b1);
        tick();
        bus.rd_req = 1'b0;
        check("prio_valid", bus.out_valid, 1'b1);
        check("prio_data", bus.psum_out, rep(11));
        tick();

        // OS handshake with 3-cycle stall; in_addr/in_first point at entry 2, which must stay untouched
        bus.os_or_ws  = 1'b1;
        bus.relu_en   = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_addr   = 4'd2;
        bus.in_first  = 1'b1;
        bus.in_valid  = 1'b1;
        bus.psum_in   = os_beat(0, 1'b0);
        tick();
        bus.out_ready = 1'b0;
        bus.psum_in   = os_beat(1, 1'b0);
        bus.rd_req    = 1'b1;
        #1;
        check("os_rd_ready", bus.rd_ready, 1'b0);
        check("os_in_ready_held", bus.in_ready, 1'b0);
        check("os_beat0", bus.psum_out, os_beat(0, 1'b1));
        bus.rd_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("os_stall_in_ready", bus.in_ready, 1'b0);
            check("os_stall_valid", bus.out_valid, 1'b1);
            check("os_stall_data", bus.psum_out, os_beat(0, 1'b1));
        end
        bus.out_ready = 1'b1;
        #1;
        check("os_in_ready_free", bus.in_ready, 1'b1);
        tick();
        check("os_beat1", bus.psum_out, os_beat(1, 1'b1));
        bus.psum_in = os_beat(2, 1'b0);
        tick();
        check("os_beat2", bus.psum_out, os_beat(2, 1'b1));
        bus.psum_in = os_beat(3, 1'b0);
        tick();
        check("os_beat3", bus.psum_out, os_beat(3, 1'b1));
        check("os_beat3_valid", bus.out_valid, 1'b1);
        bus.in_valid = 1'b0;
        tick();
        check("os_drain", bus.out_valid, 1'b0);

        bus.os_or_ws = 1'b0;
        bus.in_first = 1'b0;
        ws_read(2, 1'b0, 1'b0, d, v);
        check("os_bank_untouched", d, rep(11));

        // Asynchronous reset while a result is held
        bus.os_or_ws  = 1'b1;
        bus.relu_en   = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.psum_in   = os_beat(5, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        check("arst_pre_valid", bus.out_valid, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", bus.out_valid, 1'b0);
        check("arst_data", bus.psum_out, '0);
        #2 reset_n = 1'b1;
        bus.os_or_ws  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        ws_read(3, 1'b0, 1'b0, d, v);
        check("arst_mem3_valid", v, 1'b1);
        check("arst_mem3", d, '0);
        ws_read(2, 1'b0, 1'b0, d, v);
        check("arst_mem2", d, '0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
